vdp18_scandoubler: RTL
======================

Name: vdp18_scandoubler

Overview:
- Line-doubling stage directly downstream of the horizontal/vertical timing generator and pixel colour mux.
- Captures each 15.7 kHz (NTSC) or 15.6 kHz (PAL) line of 4-bit colour indices plus blank, written at the 5.37 MHz pixel enable.
- Replays each captured line twice at the 10.74 MHz enable, producing 31 kHz VGA-rate colour, sync and blank for the palette/DAC stage.

Parameters:
- ADDR_W, 9, line buffer address width; 512 entries, which covers the 342-pixel line.
- OUT_HSYNC_LEN, 26, output hsync low width in clk_en_10m74_i ticks.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- clk_en_5m37_i  in  1  input pixel enable; asserted on a subset of the cycles where clk_en_10m74_i is asserted
- clk_en_10m74_i  in  1  output pixel enable, twice the pixel rate
- col_i  in  4  colour index of the current pixel
- blank_i  in  1  composite blank from the timing generator
- hsync_n_i  in  1  line-rate hsync, active low
- vsync_n_i  in  1  frame vsync, active low
- col_o  out  4  doubled-rate colour index
- blank_o  out  1  doubled-rate blank
- hsync_n_o  out  1  doubled-rate hsync, active low
- vsync_n_o  out  1  vsync re-timed to the output line grid

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high; it is sampled only on the rising edge of clk_i.
- Reset values: col_o=0, blank_o=1, hsync_n_o=1, vsync_n_o=1, wr_bank=0, wr_addr=0, rd_addr=0, line_len=0, valid=0, hs_prev=1.
- Line buffer: two banks of 2^ADDR_W x 5 bits ({blank,col}), ping-pong.
  - Write bank is wr_bank; read bank is ~wr_bank.
  - Read is synchronous, 1 clk_i latency.
- Edge detect: on each clk_en_5m37_i, hs_prev<=hsync_n_i. A line edge is hs_prev=1 and hsync_n_i=0, qualified by clk_en_5m37_i.
- Write path, on each clk_en_5m37_i:
  - No edge: write {blank_i,col_i} at wr_addr; wr_addr increments, saturating at 511. At 511 the location is overwritten; no wrap.
  - Edge: wr_bank toggles; line_len<=wr_addr; wr_addr<=1 and the current pixel is written at address 0 of the new bank; rd_addr<=0; vs_line<=vsync_n_i; valid<=1 if wr_addr>=OUT_HSYNC_LEN, else 0.
- Read path, on each clk_en_10m74_i (not on a cycle that takes an edge):
  - If rd_addr == line_len-1, rd_addr wraps to 0; otherwise rd_addr increments.
  - This gives exactly two passes per input line, because line_len is counted in 5.37 MHz ticks and replayed at 10.74 MHz.
  - If line_len==0, rd_addr holds at 0.
- Edge priority: an edge on the same cycle as a read step takes priority; rd_addr<=0.
- Output register, updated on clk_en_10m74_i:
  - Pipeline: RAM read (1 cycle) then output register. The output pixel therefore trails rd_addr by one 10.74 MHz tick, with a fixed 2 clk_i pipeline.
  - col_o <= ram_col.
  - blank_o <= ram_blank | ~valid.
  - hsync_n_o <= ~(rd_addr_d < OUT_HSYNC_LEN), where rd_addr_d is rd_addr delayed to align with the data.
  - vsync_n_o <= vs_line. It changes only at the first output line boundary after an input edge, so it spans an integer number of output lines: 3 input lines give 6 output lines.
- Lost or absent hsync: if hsync_n_i never falls, wr_addr saturates and reads keep looping the last line_len from the stale bank. Output stays well-formed; content is not refreshed.
- Short line (<OUT_HSYNC_LEN): valid=0 and output is forced blank; sync is still generated.
- Reset mid-line: all state returns to reset values on the next clk_i edge. The first output is blank until a full line has been captured (two edges after reset).
- Opmode change (text 342 / graphics 342 pixels, or a different phase): handled implicitly, since line_len is re-measured every line.

Decomposition:
- vdp18_pkg gains:
  - constants scandbl_addr_w_c=9 and scandbl_hsync_len_c=26;
  - typedef scandbl_pix_t (packed struct {blank, col[3:0]}).
- One sub-module: vdp18_scandbl_ram.
  - Simple dual-port, 1024x5 (bank bit plus ADDR_W).
  - Synchronous write on we; registered read.
  - Inferable as block RAM.

Test Plan:
- Steady NTSC: 342-pixel lines, hsync_n_i low for 26 pixels per line, col_i = pixel index mod 16 -> after 2 lines line_len=342; each input line yields 2 output lines of 342 ticks; hsync_n_o low for exactly 26 ticks each; col_o sequence 0..15 repeats identically in both passes.
- Reset mid-frame: assert reset_i for 1 clk during pixel 100 -> next cycle all outputs at reset values; blank_o=1 until 2 edges have occurred; then normal doubled output.
- Vsync: vsync_n_i low across 3 input lines -> vsync_n_o low for exactly 6 output lines (2052 ticks), with transitions aligned to rd_addr=0.
- Missing hsync: hold hsync_n_i=1 for 1000 pixel enables -> wr_addr stops at 511, no wrap; output keeps repeating the last line (342 ticks) with correct hsync_n_o.
- Short line: edge after 10 pixels -> line_len=10, blank_o=1 for that replay, hsync_n_o low for all 10 ticks; a following 342-pixel line restores normal output.
- Edge coincident with rd_addr==line_len-1 -> rd_addr goes to 0, not 1; no extra or duplicated output pixel.

Source files
------------

// File: rtl/vdp18_pkg.sv
// Shared constants and types for the VDP18 video pipeline.
package vdp18_pkg;

    localparam int scandbl_addr_w_c    = 9;
    localparam int scandbl_hsync_len_c = 26;

    typedef struct packed {
        logic       blank;
        logic [3:0] col;
    } scandbl_pix_t;

endpackage

// File: rtl/vdp18_scandbl_ram.sv
// Simple dual-port line buffer: synchronous write, registered read.
module vdp18_scandbl_ram
    import vdp18_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] wr_addr,
    input  scandbl_pix_t wr_data,
    input  logic [AW-1:0] rd_addr,
    output scandbl_pix_t rd_data
);

    scandbl_pix_t mem [0:(1<<AW)-1];

    // Storage write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vdp18_scandoubler.sv
// Line doubler: captures each input line at the pixel rate into a ping-pong
// buffer and replays it twice at double rate with regenerated sync.
module vdp18_scandoubler
    import vdp18_pkg::*;
#(
    parameter int ADDR_W        = scandbl_addr_w_c,
    parameter int OUT_HSYNC_LEN = scandbl_hsync_len_c
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clk_en_5m37_i,
    input  logic       clk_en_10m74_i,
    input  logic [3:0] col_i,
    input  logic       blank_i,
    input  logic       hsync_n_i,
    input  logic       vsync_n_i,
    output logic [3:0] col_o,
    output logic       blank_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o
);

    localparam logic [ADDR_W-1:0] zero_c      = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] one_c       = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] addr_max_c  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] hsync_len_c = ADDR_W'(OUT_HSYNC_LEN);

    logic              wr_bank_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [ADDR_W-1:0] rd_addr_d_r;
    logic [ADDR_W-1:0] line_len_r;
    logic              valid_r;
    logic              primed_r;
    logic              hs_prev_r;
    logic              vs_line_r;

    logic              line_edge_s;
    logic [ADDR_W:0]   ram_wr_addr_s;
    logic [ADDR_W:0]   ram_rd_addr_s;
    logic [ADDR_W-1:0] rd_next_s;
    scandbl_pix_t      wr_data_s;
    scandbl_pix_t      ram_rd_data_s;

    // Line edge detect, RAM addressing and read-pointer advance.
    always_comb begin
        line_edge_s     = clk_en_5m37_i & hs_prev_r & ~hsync_n_i;
        wr_data_s.blank = blank_i;
        wr_data_s.col   = col_i;
        ram_rd_addr_s   = {~wr_bank_r, rd_addr_r};
        // The pixel that coincides with the edge opens the new bank at 0.
        if (line_edge_s) begin
            ram_wr_addr_s = {~wr_bank_r, zero_c};
        end else begin
            ram_wr_addr_s = {wr_bank_r, wr_addr_r};
        end
        rd_next_s = zero_c;
        if (line_len_r == zero_c) begin
            rd_next_s = zero_c;
        end else if (rd_addr_r == (line_len_r - one_c)) begin
            rd_next_s = zero_c;
        end else begin
            rd_next_s = rd_addr_r + one_c;
        end
    end

    vdp18_scandbl_ram #(
        .AW (ADDR_W + 1)
    ) u_ram (
        .clk     (clk_i),
        .we      (clk_en_5m37_i),
        .wr_addr (ram_wr_addr_s),
        .wr_data (wr_data_s),
        .rd_addr (ram_rd_addr_s),
        .rd_data (ram_rd_data_s)
    );

    // Capture/replay state and the registered output stage.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_bank_r   <= 1'b0;
            wr_addr_r   <= zero_c;
            rd_addr_r   <= zero_c;
            rd_addr_d_r <= zero_c;
            line_len_r  <= zero_c;
            valid_r     <= 1'b0;
            primed_r    <= 1'b0;
            hs_prev_r   <= 1'b1;
            vs_line_r   <= 1'b1;
            col_o       <= 4'd0;
            blank_o     <= 1'b1;
            hsync_n_o   <= 1'b1;
            vsync_n_o   <= 1'b1;
        end else begin
            if (clk_en_5m37_i) begin
                hs_prev_r <= hsync_n_i;
                if (line_edge_s) begin
                    wr_bank_r  <= ~wr_bank_r;
                    line_len_r <= wr_addr_r;
                    wr_addr_r  <= one_c;
                    vs_line_r  <= vsync_n_i;
                    // The first edge after reset closes a partial line.
                    valid_r    <= primed_r & (wr_addr_r >= hsync_len_c);
                    primed_r   <= 1'b1;
                end else if (wr_addr_r != addr_max_c) begin
                    wr_addr_r <= wr_addr_r + one_c;
                end
            end
            if (line_edge_s) begin
                rd_addr_r <= zero_c;
            end else if (clk_en_10m74_i) begin
                rd_addr_r <= rd_next_s;
            end
            rd_addr_d_r <= rd_addr_r;
            if (clk_en_10m74_i) begin
                col_o     <= ram_rd_data_s.col;
                blank_o   <= ram_rd_data_s.blank | ~valid_r;
                hsync_n_o <= ~(rd_addr_d_r < hsync_len_c);
                // Vsync only moves on an output line boundary.
                if (rd_addr_d_r == zero_c) begin
                    vsync_n_o <= vs_line_r;
                end
            end
        end
    end

endmodule
